// File: rtl/dds_phase_gen_if.sv
// Bus bundle for dds_phase_gen: FTW load port, phase offset, run level and the phase sample stream.
// Stream: a beat transfers when phase_valid_o & phase_ready_i on a rising edge; valid never retracts and phase_o holds until then.
interface dds_phase_gen_if #(
  parameter int ACC_WIDTH   = 32,
  parameter int PHASE_WIDTH = 12
);
  logic [ACC_WIDTH-1:0]   ftw_i;
  logic                   ftw_valid_i;
  logic                   ftw_ready_o;
  logic [PHASE_WIDTH-1:0] pofs_i;
  logic                   run_i;
  logic [PHASE_WIDTH-1:0] phase_o;
  logic                   phase_valid_o;
  logic                   phase_ready_i;
  logic                   wrap_o;
  logic [1:0]             state_o;

  modport slave (
    input  ftw_i, ftw_valid_i, pofs_i, run_i, phase_ready_i,
    output ftw_ready_o, phase_o, phase_valid_o, wrap_o, state_o
  );

  modport master (
    output ftw_i, ftw_valid_i, pofs_i, run_i, phase_ready_i,
    input  ftw_ready_o, phase_o, phase_valid_o, wrap_o, state_o
  );
endinterface

// File: rtl/dds_phase_gen.sv
// DDS phase accumulator streaming truncated, offset phase samples to the sine ROM address path.
// Optional LFSR dithering of the truncated LSBs is enabled by defining DDS_PHASE_DITHER_EN.
module dds_phase_gen #(
  parameter int ACC_WIDTH    = 32,
  parameter int PHASE_WIDTH  = 12,
  parameter int DITHER_WIDTH = 4
) (
  input  logic           clk_i,
  input  logic           rst_i,
  dds_phase_gen_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRIME = 2'd1,
    ST_RUN   = 2'd2,
    ST_DRAIN = 2'd3
  } state_e;

  localparam int DITHER_SHIFT = ACC_WIDTH - PHASE_WIDTH - DITHER_WIDTH;

  state_e                 state_q;
  logic [ACC_WIDTH-1:0]   acc_q;
  logic [ACC_WIDTH-1:0]   ftw_q;
  logic [PHASE_WIDTH-1:0] phase_q;
  logic                   valid_q;
  logic                   wrap_q;
  logic                   ftw_ready_q;

  logic                    hs;
  logic                    ftw_load;
  logic [ACC_WIDTH:0]      sum;
  logic [ACC_WIDTH-1:0]    acc_nxt;
  logic                    carry;
  logic [ACC_WIDTH-1:0]    acc_dith;
  logic [DITHER_WIDTH-1:0] dither_bits;
  logic [PHASE_WIDTH-1:0]  phase_nxt;
  logic [PHASE_WIDTH-1:0]  phase_first;

  assign hs       = valid_q & bus.phase_ready_i;
  assign ftw_load = bus.ftw_valid_i & ftw_ready_q;

  assign sum      = {1'b0, acc_q} + {1'b0, ftw_q};
  assign acc_nxt  = sum[ACC_WIDTH-1:0];
  assign carry    = sum[ACC_WIDTH];

  // Dither only perturbs the value being truncated; the accumulator stays exact.
  assign acc_dith    = acc_nxt + ({{(ACC_WIDTH-DITHER_WIDTH){1'b0}}, dither_bits} << DITHER_SHIFT);
  assign phase_nxt   = acc_dith[ACC_WIDTH-1 -: PHASE_WIDTH] + bus.pofs_i;
  assign phase_first = acc_q[ACC_WIDTH-1 -: PHASE_WIDTH] + bus.pofs_i;

`ifdef DDS_PHASE_DITHER_EN
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;

  // Galois form of x^16+x^14+x^13+x^11+1; held at the seed while idle.
  always_comb begin
    lfsr_d = lfsr_q;
    if (state_q == ST_IDLE) begin
      lfsr_d = LFSR_SEED;
    end else if (hs) begin
      lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign dither_bits = lfsr_q[DITHER_WIDTH-1:0];
`else
  assign dither_bits = '0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ftw_q       <= '0;
      ftw_ready_q <= 1'b0;
    end else begin
      ftw_ready_q <= 1'b1;
      if (ftw_load) begin
        ftw_q <= bus.ftw_i;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      phase_q <= '0;
      valid_q <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      wrap_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          acc_q   <= '0;
          valid_q <= 1'b0;
          if (bus.run_i) begin
            state_q <= ST_PRIME;
          end
        end
        ST_PRIME: begin
          phase_q <= phase_first;
          valid_q <= 1'b1;
          state_q <= ST_RUN;
        end
        ST_RUN: begin
          if (hs) begin
            if (bus.run_i) begin
              acc_q   <= acc_nxt;
              phase_q <= phase_nxt;
              wrap_q  <= carry;
            end else begin
              acc_q   <= '0;
              valid_q <= 1'b0;
              state_q <= ST_IDLE;
            end
          end else if (!bus.run_i) begin
            state_q <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          // run_i is deliberately ignored here; the held sample must leave first.
          if (hs) begin
            acc_q   <= '0;
            valid_q <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.ftw_ready_o   = ftw_ready_q;
  assign bus.phase_o       = phase_q;
  assign bus.phase_valid_o = valid_q;
  assign bus.wrap_o        = wrap_q;
  assign bus.state_o       = state_q;

endmodule

// File: tb/tb_dds_phase_gen.sv
// Bench for dds_phase_gen: directed vector table, hand sequences and random traffic against an arithmetic model.
module tb_dds_phase_gen;
  localparam int AW = 32;
  localparam int PW = 12;
  localparam int DW = 4;
  localparam longint unsigned ACC_MOD      = 64'd1 << AW;
  localparam longint unsigned PHASE_MOD    = 64'd1 << PW;
  localparam longint unsigned DITHER_SCALE = 64'd1 << (AW - PW - DW);

  logic clk_i = 1'b0;
  logic rst_i;

  dds_phase_gen_if #(.ACC_WIDTH(AW), .PHASE_WIDTH(PW)) bus ();

  dds_phase_gen #(
    .ACC_WIDTH(AW),
    .PHASE_WIDTH(PW),
    .DITHER_WIDTH(DW)
  ) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .bus  (bus)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;
  logic [PW-1:0] exp_q[$];

  // Reference model: plain integer arithmetic on the accumulator value.
  longint unsigned m_acc;
  longint unsigned m_ftw;
  bit              m_valid;
  bit              m_prime;
  bit              m_stop;
  bit              m_wrap;
  bit              m_fr;
  int unsigned     m_phase;
  bit [15:0]       m_lfsr;

  typedef struct {
    bit          fv;
    logic [31:0] ftw;
    logic [11:0] pofs;
    bit          run;
    bit          rdy;
    bit          ev;
    logic [11:0] ep;
    bit          ew;
  } vec_t;

  vec_t vq[$];

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic bit [15:0] lfsr_next(bit [15:0] s);
    return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
  endfunction

  function automatic int unsigned model_phase(longint unsigned acc, int unsigned pofs);
    longint unsigned a;
    a = acc;
`ifdef DDS_PHASE_DITHER_EN
    a = (a + longint'(m_lfsr[DW-1:0]) * DITHER_SCALE) % ACC_MOD;
`endif
    return 32'(((a >> (AW - PW)) + longint'(pofs)) % PHASE_MOD);
  endfunction

  task automatic model_edge();
    bit hs;
    longint unsigned sum;
    if (rst_i) begin
      m_acc = 0; m_ftw = 0; m_valid = 0; m_prime = 0; m_stop = 0;
      m_wrap = 0; m_fr = 0; m_phase = 0; m_lfsr = 16'hACE1;
      exp_q.delete();
      return;
    end
    hs = m_valid && bus.phase_ready_i;
    m_wrap = 0;
    if (m_valid) begin
      if (hs && (m_stop || !bus.run_i)) begin
        m_valid = 0; m_stop = 0; m_acc = 0;
      end else if (hs) begin
        sum     = m_acc + m_ftw;
        m_wrap  = (sum >= ACC_MOD);
        m_acc   = sum % ACC_MOD;
        m_phase = model_phase(m_acc, 32'(bus.pofs_i));
        exp_q.push_back(PW'(m_phase));
      end else if (!bus.run_i) begin
        m_stop = 1;
      end
      if (hs) m_lfsr = lfsr_next(m_lfsr);
    end else if (m_prime) begin
      m_prime = 0;
      m_valid = 1;
      m_phase = 32'(bus.pofs_i);
      exp_q.push_back(PW'(m_phase));
    end else begin
      m_lfsr = 16'hACE1;
      if (bus.run_i) m_prime = 1;
    end
    if (bus.ftw_valid_i && m_fr) m_ftw = longint'(bus.ftw_i);
    m_fr = 1;
  endtask

  task automatic check_outputs();
    chk("valid", 64'(bus.phase_valid_o), 64'(m_valid));
    chk("wrap", 64'(bus.wrap_o), 64'(m_wrap));
    chk("ftw_ready", 64'(bus.ftw_ready_o), 64'(m_fr));
    if (m_valid || rst_i) chk("phase", 64'(bus.phase_o), 64'(m_phase));
  endtask

  task automatic tick();
    if (!rst_i && bus.phase_valid_o && bus.phase_ready_i) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_empty actual=beat required=no_beat t=%0t", $time);
      end else begin
        chk("sb_phase", 64'(bus.phase_o), 64'(exp_q.pop_front()));
      end
    end
    model_edge();
    @(posedge clk_i);
    #1;
    check_outputs();
  endtask

  task automatic add(bit fv, logic [31:0] ftw, logic [11:0] pofs, bit run, bit rdy,
                     bit ev, logic [11:0] ep, bit ew);
    vec_t v;
    v.fv = fv; v.ftw = ftw; v.pofs = pofs; v.run = run; v.rdy = rdy;
    v.ev = ev; v.ep = ep; v.ew = ew;
    vq.push_back(v);
  endtask

  initial begin
    rst_i = 1'b1;
    bus.ftw_i = '0;
    bus.ftw_valid_i = 1'b0;
    bus.pofs_i = '0;
    bus.run_i = 1'b0;
    bus.phase_ready_i = 1'b1;

    // Step 1/step 2 sweep, backpressure, wrap at half-scale FTW, offset wrap, load on a beat, drain, restart.
    add(0, 32'h0, 12'h000, 0, 1, 0, 12'h000, 0);
    add(1, 32'h0010_0000, 12'h000, 0, 1, 0, 12'h000, 0);
    add(0, 32'h0, 12'h000, 1, 1, 0, 12'h000, 0);
    add(0, 32'h0, 12'h000, 1, 1, 1, 12'h000, 0);
    add(0, 32'h0, 12'h000, 1, 1, 1, 12'h001, 0);
    add(0, 32'h0, 12'h000, 1, 1, 1, 12'h002, 0);
    add(0, 32'h0, 12'h000, 1, 0, 1, 12'h002, 0);
    add(0, 32'h0, 12'h000, 1, 0, 1, 12'h002, 0);
    add(0, 32'h0, 12'h000, 1, 1, 1, 12'h003, 0);
    add(0, 32'h0, 12'h000, 0, 1, 0, 12'h000, 0);
    add(1, 32'h8000_0000, 12'h000, 0, 1, 0, 12'h000, 0);
    add(0, 32'h0, 12'h000, 1, 1, 0, 12'h000, 0);
    add(0, 32'h0, 12'h000, 1, 1, 1, 12'h000, 0);
    add(0, 32'h0, 12'h000, 1, 1, 1, 12'h800, 0);
    add(0, 32'h0, 12'h000, 1, 1, 1, 12'h000, 1);
    add(0, 32'h0, 12'h000, 1, 1, 1, 12'h800, 0);
    add(0, 32'h0, 12'h000, 1, 0, 1, 12'h800, 0);
    add(0, 32'h0, 12'h000, 1, 1, 1, 12'h000, 1);
    add(0, 32'h0, 12'h000, 0, 1, 0, 12'h000, 0);
    add(1, 32'h0010_0000, 12'hFFF, 1, 1, 0, 12'h000, 0);
    add(0, 32'h0, 12'hFFF, 1, 1, 1, 12'hFFF, 0);
    add(0, 32'h0, 12'hFFF, 1, 1, 1, 12'h000, 0);
    add(1, 32'h0020_0000, 12'hFFF, 1, 1, 1, 12'h001, 0);
    add(0, 32'h0, 12'hFFF, 1, 1, 1, 12'h003, 0);
    add(0, 32'h0, 12'hFFF, 1, 1, 1, 12'h005, 0);
    add(0, 32'h0, 12'hFFF, 0, 0, 1, 12'h005, 0);
    add(0, 32'h0, 12'hFFF, 1, 0, 1, 12'h005, 0);
    add(0, 32'h0, 12'hFFF, 1, 1, 0, 12'h000, 0);
    add(0, 32'h0, 12'hFFF, 1, 1, 0, 12'h000, 0);
    add(0, 32'h0, 12'hFFF, 1, 1, 1, 12'hFFF, 0);
    add(0, 32'h0, 12'hFFF, 1, 1, 1, 12'h001, 0);

    repeat (3) tick();
    chk("rst_valid", 64'(bus.phase_valid_o), 64'd0);
    chk("rst_ftw_ready", 64'(bus.ftw_ready_o), 64'd0);
    chk("rst_phase", 64'(bus.phase_o), 64'd0);
    rst_i = 1'b0;

    foreach (vq[i]) begin
      bus.ftw_valid_i   = vq[i].fv;
      bus.ftw_i         = vq[i].ftw;
      bus.pofs_i        = vq[i].pofs;
      bus.run_i         = vq[i].run;
      bus.phase_ready_i = vq[i].rdy;
      tick();
      chk("tbl_valid", 64'(bus.phase_valid_o), 64'(vq[i].ev));
      chk("tbl_wrap", 64'(bus.wrap_o), 64'(vq[i].ew));
      if (vq[i].ev) chk("tbl_phase", 64'(bus.phase_o), 64'(vq[i].ep));
    end
    bus.ftw_valid_i = 1'b0;

    // Five cycles of backpressure on sample 0x001, then the next sample with no skip.
    bus.phase_ready_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_valid", 64'(bus.phase_valid_o), 64'd1);
      chk("bp_phase", 64'(bus.phase_o), 64'h001);
    end
    bus.phase_ready_i = 1'b1;
    tick();
    chk("bp_resume", 64'(bus.phase_o), 64'h003);

    // Reset in the middle of a running stream.
    rst_i = 1'b1;
    tick();
    chk("midrst_valid", 64'(bus.phase_valid_o), 64'd0);
    chk("midrst_phase", 64'(bus.phase_o), 64'd0);
    chk("midrst_wrap", 64'(bus.wrap_o), 64'd0);
    rst_i = 1'b0;

    // Zero FTW after reset: constant phase equal to the offset, never a wrap.
    bus.pofs_i = 12'h5A5;
    bus.run_i  = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (i >= 1) chk("zero_ftw_phase", 64'(bus.phase_o), 64'h5A5);
      chk("zero_ftw_wrap", 64'(bus.wrap_o), 64'd0);
    end

    // Random traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      rst_i = ($urandom_range(0, 999) == 0);
      bus.phase_ready_i = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 49) == 0) bus.run_i = ~bus.run_i;
      bus.ftw_valid_i = ($urandom_range(0, 19) == 0);
      case ($urandom_range(0, 2))
        0: bus.ftw_i = $urandom();
        1: bus.ftw_i = $urandom_range(0, 32'h0040_0000);
        default: bus.ftw_i = 32'h8000_0000 + $urandom_range(0, 255);
      endcase
      if ($urandom_range(0, 9) == 0) bus.pofs_i = PW'($urandom());
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
